// File: rtl/id_ex_pkg.sv
// Shared widths, control-bundle layout and register-match helper for the ID->EX stage.
package id_ex_pkg;
  localparam int DEF_XLEN  = 32;
  localparam int DEF_FLEN  = 32;
  localparam int DEF_IMM_W = 32;
  localparam int DEF_NSRC  = 3;
  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] X0 = 5'd0;

  // Control bundle layout: ALU selects, memory enables, FPU selects.
  localparam int CTRL_ALU_LSB = 0;
  localparam int CTRL_ALU_W   = 16;
  localparam int CTRL_MEM_LSB = CTRL_ALU_LSB + CTRL_ALU_W;
  localparam int CTRL_MEM_W   = 8;
  localparam int CTRL_FPU_LSB = CTRL_MEM_LSB + CTRL_MEM_W;
  localparam int CTRL_FPU_W   = 16;
  localparam int DEF_CTRL_W   = CTRL_FPU_LSB + CTRL_FPU_W;

  // x0 is hardwired zero, so integer write-back to it never forwards; f0 is a real register.
  function automatic logic idx_hit(input logic we, input logic [REG_IDX_W-1:0] wb_rd,
                                   input logic [REG_IDX_W-1:0] rs, input logic skip_x0);
    return we && (wb_rd == rs) && !(skip_x0 && (wb_rd == X0));
  endfunction
endpackage

// File: rtl/id_ex_wb_bypass.sv
// One source operand's write-back compare and int/fp forwarding mux.
module id_ex_wb_bypass
  import id_ex_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int FLEN = DEF_FLEN
) (
  input  logic [REG_IDX_W-1:0] rs_idx,
  input  logic [XLEN-1:0]      rf_i,
  input  logic [FLEN-1:0]      rf_f,
  input  logic                 wb_i_we,
  input  logic                 wb_f_we,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_i_data,
  input  logic [FLEN-1:0]      wb_f_data,
  output logic [XLEN-1:0]      i_data,
  output logic [FLEN-1:0]      f_data,
  output logic                 i_hit,
  output logic                 f_hit
);
  assign i_hit  = idx_hit(wb_i_we, wb_rd, rs_idx, 1'b1);
  assign f_hit  = idx_hit(wb_f_we, wb_rd, rs_idx, 1'b0);
  assign i_data = i_hit ? wb_i_data : rf_i;
  assign f_data = f_hit ? wb_f_data : rf_f;
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with handshake, flush and WB->ID bypass.
// Define ID_EX_WB_BYPASS_EN to enable capture bypass and hold-refresh of stalled operands.
module id_ex_stage_reg
  import id_ex_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int FLEN   = DEF_FLEN,
  parameter int IMM_W  = DEF_IMM_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int NSRC   = DEF_NSRC
) (
  input  logic                      CLK,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_pc,
  input  logic [IMM_W-1:0]          in_imm,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [NSRC*REG_IDX_W-1:0] in_rs_idx,
  input  logic [NSRC*XLEN-1:0]      in_irs_data,
  input  logic [NSRC*FLEN-1:0]      in_frs_data,
  input  logic [REG_IDX_W-1:0]      in_rd,
  input  logic                      wb_i_we,
  input  logic                      wb_f_we,
  input  logic [REG_IDX_W-1:0]      wb_rd,
  input  logic [XLEN-1:0]           wb_i_data,
  input  logic [FLEN-1:0]           wb_f_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_pc,
  output logic [IMM_W-1:0]          out_imm,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [NSRC*REG_IDX_W-1:0] out_rs_idx,
  output logic [REG_IDX_W-1:0]      out_rd,
  output logic [NSRC*XLEN-1:0]      out_irs_data,
  output logic [NSRC*FLEN-1:0]      out_frs_data,
  output logic [NSRC-1:0]           out_byp
);
  logic byp_i_we, byp_f_we;

  // With bypass disabled the forwarding muxes see no write-back and pass RF data through.
`ifdef ID_EX_WB_BYPASS_EN
  assign byp_i_we = wb_i_we;
  assign byp_f_we = wb_f_we;
`else
  logic wb_we_unused;
  assign byp_i_we     = 1'b0;
  assign byp_f_we     = 1'b0;
  assign wb_we_unused = wb_i_we ^ wb_f_we;
`endif

  logic capture, hold;
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign hold     = out_valid && !out_ready;

  logic [NSRC*XLEN-1:0] cap_i, hld_i;
  logic [NSRC*FLEN-1:0] cap_f, hld_f;
  logic [NSRC-1:0]      cap_ih, cap_fh, hld_ih, hld_fh;

  for (genvar j = 0; j < NSRC; j++) begin : g_src
    id_ex_wb_bypass #(.XLEN(XLEN), .FLEN(FLEN)) u_cap (
      .rs_idx   (in_rs_idx[j*REG_IDX_W +: REG_IDX_W]),
      .rf_i     (in_irs_data[j*XLEN +: XLEN]),
      .rf_f     (in_frs_data[j*FLEN +: FLEN]),
      .wb_i_we  (byp_i_we),
      .wb_f_we  (byp_f_we),
      .wb_rd    (wb_rd),
      .wb_i_data(wb_i_data),
      .wb_f_data(wb_f_data),
      .i_data   (cap_i[j*XLEN +: XLEN]),
      .f_data   (cap_f[j*FLEN +: FLEN]),
      .i_hit    (cap_ih[j]),
      .f_hit    (cap_fh[j])
    );
    id_ex_wb_bypass #(.XLEN(XLEN), .FLEN(FLEN)) u_hld (
      .rs_idx   (out_rs_idx[j*REG_IDX_W +: REG_IDX_W]),
      .rf_i     (out_irs_data[j*XLEN +: XLEN]),
      .rf_f     (out_frs_data[j*FLEN +: FLEN]),
      .wb_i_we  (byp_i_we),
      .wb_f_we  (byp_f_we),
      .wb_rd    (wb_rd),
      .wb_i_data(wb_i_data),
      .wb_f_data(wb_f_data),
      .i_data   (hld_i[j*XLEN +: XLEN]),
      .f_data   (hld_f[j*FLEN +: FLEN]),
      .i_hit    (hld_ih[j]),
      .f_hit    (hld_fh[j])
    );
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_imm      <= '0;
      out_ctrl     <= '0;
      out_rs_idx   <= '0;
      out_rd       <= '0;
      out_irs_data <= '0;
      out_frs_data <= '0;
      out_byp      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_byp   <= '0;
    end else if (capture) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_imm      <= in_imm;
      out_ctrl     <= in_ctrl;
      out_rs_idx   <= in_rs_idx;
      out_rd       <= in_rd;
      out_irs_data <= cap_i;
      out_frs_data <= cap_f;
      out_byp      <= cap_ih | cap_fh;
    end else if (hold) begin
      // Stalled: keep held operands coherent with write-back.
      out_irs_data <= hld_i;
      out_frs_data <= hld_f;
      out_byp      <= out_byp | hld_ih | hld_fh;
    end else begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg with an instruction-slot model and per-cycle compare.
module tb_id_ex_stage_reg;
`ifdef ID_EX_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic rst_n;
  logic flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]  in_pc, in_imm, out_pc, out_imm;
  logic [39:0]  in_ctrl, out_ctrl;
  logic [14:0]  in_rs_idx, out_rs_idx;
  logic [95:0]  in_irs_data, in_frs_data, out_irs_data, out_frs_data;
  logic [4:0]   in_rd, out_rd, wb_rd;
  logic         wb_i_we, wb_f_we;
  logic [31:0]  wb_i_data, wb_f_data;
  logic [2:0]   out_byp;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  id_ex_stage_reg dut (
    .CLK(CLK), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_ctrl(in_ctrl), .in_rs_idx(in_rs_idx),
    .in_irs_data(in_irs_data), .in_frs_data(in_frs_data), .in_rd(in_rd),
    .wb_i_we(wb_i_we), .wb_f_we(wb_f_we), .wb_rd(wb_rd), .wb_i_data(wb_i_data),
    .wb_f_data(wb_f_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_ctrl(out_ctrl), .out_rs_idx(out_rs_idx),
    .out_rd(out_rd), .out_irs_data(out_irs_data), .out_frs_data(out_frs_data),
    .out_byp(out_byp)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one instruction slot, operands as plain arrays.
  logic        m_valid;
  logic [31:0] m_pc, m_imm;
  logic [39:0] m_ctrl;
  logic [4:0]  m_rd;
  logic [4:0]  m_rs  [3];
  logic [31:0] m_irs [3];
  logic [31:0] m_frs [3];
  logic [2:0]  m_byp;

  function automatic bit fwd_int(input logic we, input logic [4:0] rd, input logic [4:0] src);
    return BYP && we && rd != 0 && rd == src;
  endfunction
  function automatic bit fwd_fp(input logic we, input logic [4:0] rd, input logic [4:0] src);
    return BYP && we && rd == src;
  endfunction

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_pc <= 0; m_imm <= 0; m_ctrl <= 0; m_rd <= 0; m_byp <= 0;
      for (int j = 0; j < 3; j++) begin m_rs[j] <= 0; m_irs[j] <= 0; m_frs[j] <= 0; end
    end else if (flush) begin
      m_valid <= 0; m_ctrl <= 0; m_byp <= 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1; m_pc <= in_pc; m_imm <= in_imm; m_ctrl <= in_ctrl; m_rd <= in_rd;
      for (int j = 0; j < 3; j++) begin
        m_rs[j]  <= in_rs_idx[5*j +: 5];
        m_irs[j] <= fwd_int(wb_i_we, wb_rd, in_rs_idx[5*j +: 5]) ? wb_i_data : in_irs_data[32*j +: 32];
        m_frs[j] <= fwd_fp(wb_f_we, wb_rd, in_rs_idx[5*j +: 5]) ? wb_f_data : in_frs_data[32*j +: 32];
        m_byp[j] <= fwd_int(wb_i_we, wb_rd, in_rs_idx[5*j +: 5]) || fwd_fp(wb_f_we, wb_rd, in_rs_idx[5*j +: 5]);
      end
    end else if (m_valid && !out_ready) begin
      for (int j = 0; j < 3; j++) begin
        if (fwd_int(wb_i_we, wb_rd, m_rs[j])) m_irs[j] <= wb_i_data;
        if (fwd_fp(wb_f_we, wb_rd, m_rs[j]))  m_frs[j] <= wb_f_data;
        if (fwd_int(wb_i_we, wb_rd, m_rs[j]) || fwd_fp(wb_f_we, wb_rd, m_rs[j])) m_byp[j] <= 1'b1;
      end
    end else begin
      m_valid <= 0;
    end
  end

  always @(negedge CLK) begin
    logic [14:0] e_rs;
    logic [95:0] e_irs, e_frs;
    for (int j = 0; j < 3; j++) begin
      e_rs[5*j +: 5] = m_rs[j]; e_irs[32*j +: 32] = m_irs[j]; e_frs[32*j +: 32] = m_frs[j];
    end
    chk("cyc in_ready", in_ready, !m_valid || out_ready);
    chk("cyc out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("cyc out_pc", out_pc, m_pc);
      chk("cyc out_imm", out_imm, m_imm);
      chk("cyc out_ctrl", out_ctrl, m_ctrl);
      chk("cyc out_rd", out_rd, m_rd);
      chk("cyc out_rs_idx", out_rs_idx, e_rs);
      chk("cyc out_irs_data", out_irs_data, e_irs);
      chk("cyc out_frs_data", out_frs_data, e_frs);
      chk("cyc out_byp", out_byp, m_byp);
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] r0, r1, r2,
                       input logic [31:0] i0, i1, i2, input logic [31:0] f0, f1, f2);
    in_valid = 1; in_pc = pc; in_imm = pc ^ 32'hFFFF_0000; in_ctrl = {8'hC3, pc};
    in_rd = pc[6:2]; in_rs_idx = {r2, r1, r0};
    in_irs_data = {i2, i1, i0}; in_frs_data = {f2, f1, f0};
  endtask

  task automatic wb(input logic iwe, fwe, input logic [4:0] rd, input logic [31:0] idat, fdat);
    wb_i_we = iwe; wb_f_we = fwe; wb_rd = rd; wb_i_data = idat; wb_f_data = fdat;
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    issue(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0); in_valid = 0;
    wb(0, 0, 0, 0, 0);
    #12;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_byp", out_byp, 0);
    chk("reset out_ctrl", out_ctrl, 0);
    chk("reset out_irs", out_irs_data, 0);
    chk("reset in_ready", in_ready, 1);
    rst_n = 1;
    step();

    // 1: plain capture
    issue(32'h100, 5, 1, 2, 32'h11, 32'h22, 32'h33, 32'hF1, 32'hF2, 32'hF3);
    step();
    chk("t1 out_valid", out_valid, 1);
    chk("t1 irs0", out_irs_data[31:0], 32'h11);
    chk("t1 byp", out_byp, 3'b000);

    // 2: both int operands forwarded
    issue(32'h104, 7, 7, 3, 32'h70, 32'h71, 32'h33, 0, 0, 0);
    wb(1, 0, 7, 32'hDEAD, 32'h0);
    step();
    chk("t2 irs0", out_irs_data[31:0], BYP ? 32'hDEAD : 32'h70);
    chk("t2 irs1", out_irs_data[63:32], BYP ? 32'hDEAD : 32'h71);
    chk("t2 irs2", out_irs_data[95:64], 32'h33);
    chk("t2 byp", out_byp, BYP ? 3'b011 : 3'b000);

    // 3: x0 never forwards, f0 does
    issue(32'h108, 0, 1, 2, 32'h0, 32'h1, 32'h2, 32'hF0, 32'hF1, 32'hF2);
    wb(1, 0, 0, 32'h55, 32'h0);
    step();
    chk("t3 int x0", out_irs_data[31:0], 32'h0);
    chk("t3 int byp", out_byp, 3'b000);
    wb(0, 1, 0, 32'h0, 32'h55);
    step();
    chk("t3 fp f0", out_frs_data[31:0], BYP ? 32'h55 : 32'hF0);
    chk("t3 fp byp", out_byp, BYP ? 3'b001 : 3'b000);

    // 4: hold-refresh while stalled
    wb(0, 0, 0, 0, 0);
    issue(32'h200, 1, 9, 2, 32'h10, 32'h90, 32'h20, 0, 0, 0);
    step();
    out_ready = 0;
    issue(32'h300, 4, 4, 4, 0, 0, 0, 0, 0, 0);
    wb(1, 0, 9, 32'h1234, 32'h0);
    step();
    chk("t4 in_ready", in_ready, 0);
    chk("t4 irs1", out_irs_data[63:32], BYP ? 32'h1234 : 32'h90);
    chk("t4 byp", out_byp, BYP ? 3'b010 : 3'b000);
    wb(0, 0, 0, 0, 0);
    step();
    chk("t4 in_ready hold", in_ready, 0);
    chk("t4 pc hold", out_pc, 32'h200);

    // 6: asynchronous reset mid-stall
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("t6 async valid", out_valid, 0);
    chk("t6 async irs", out_irs_data, 0);
    chk("t6 async pc", out_pc, 0);
    rst_n = 1;
    out_ready = 1;
    step();

    // 5: flush beats a simultaneous capture
    issue(32'h400, 1, 2, 3, 32'h1, 32'h2, 32'h3, 0, 0, 0);
    step();
    issue(32'h404, 1, 2, 3, 32'h4, 32'h5, 32'h6, 0, 0, 0);
    flush = 1;
    step();
    chk("t5 flush valid", out_valid, 0);
    chk("t5 flush ctrl", out_ctrl, 0);
    flush = 0;
    issue(32'h408, 1, 2, 3, 32'h7, 32'h8, 32'h9, 0, 0, 0);
    step();
    chk("t5 recapture valid", out_valid, 1);
    chk("t5 recapture pc", out_pc, 32'h408);
    chk("t5 recapture ctrl", out_ctrl, 40'hC3_0000_0408);
    in_valid = 0;
    step();
    chk("t5 drain valid", out_valid, 0);

    // mixed traffic checked by the model
    for (int i = 0; i < 16; i++) begin
      issue(32'h1000 + 32'(4 * i), 5'(i % 8), 5'((i + 1) % 8), 5'((i + 5) % 8),
            32'(i), 32'(i + 100), 32'(i + 200), 32'(i + 300), 32'(i + 400), 32'(i + 500));
      in_valid  = (i % 3) != 0;
      out_ready = (i % 4) != 1;
      flush     = (i == 9);
      wb(1'(i % 2), 1'((i / 2) % 2), 5'((3 * i) % 8), 32'hA000 + 32'(i), 32'hB000 + 32'(i));
      step();
    end
    flush = 0; in_valid = 0; out_ready = 1; wb(0, 0, 0, 0, 0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
